// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: opcode and FSM state encodings.
// Helper functions decode the opcode into divide/signed flags.
package mdu_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } mdu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } mdu_state_t;

   function automatic logic op_is_div(input mdu_op_t op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input mdu_op_t op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/mdu_if.sv
// Control/operand/result bundle between the datapath control FSM (master) and the MDU (slave).
interface mdu_if
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) ();
   logic             start;
   mdu_op_t          op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, hi_we, lo_we, wdata,
      input  busy, done, div_zero, hi, lo
   );

   modport slave (
      input  start, op, a, b, hi_we, lo_we, wdata,
      output busy, done, div_zero, hi, lo
   );
endinterface

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate: res = neg ? -val : val (wraps modulo 2^WIDTH).
// Purely combinational; used for operand magnitudes and for result sign fixup.
module mdu_sign_fix #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] val,
   input  logic             neg,
   output logic [WIDTH-1:0] res
);
   assign res = neg ? (~val + WIDTH'(1)) : val;
endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO registers; done at start+WIDTH+2, one op in flight, start ignored unless IDLE.
// MDU_DIVZERO_EXC_EN: a divide by zero completes at start+1 with div_zero set and hi/lo untouched.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic Clk,
   input  logic reset,
   mdu_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   mdu_state_t         state_q, state_d;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   opnd_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   rem_q;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               is_div_q, neg_q, rneg_q;
`ifdef MDU_DIVZERO_EXC_EN
   logic               dz_q;
`endif

   logic               sgn_op, div_op, b_zero, dz_case, sa, sb, last_step;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [WIDTH:0]     mul_sum, shifted, diff;
   logic               ge;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign sgn_op    = op_is_signed(bus.op);
   assign div_op    = op_is_div(bus.op);
   assign b_zero    = (bus.b == '0);
   assign dz_case   = div_op & b_zero;
   // Divide by zero keeps the raw dividend so the remainder comes out as a, unfixed.
   assign sa        = sgn_op & bus.a[WIDTH-1] & ~dz_case;
   assign sb        = sgn_op & bus.b[WIDTH-1];
   assign last_step = (cnt_q == CW'(WIDTH - 1));

   mdu_sign_fix #(.WIDTH(WIDTH))   u_abs_a  (.val(bus.a),              .neg(sa),     .res(a_abs));
   mdu_sign_fix #(.WIDTH(WIDTH))   u_abs_b  (.val(bus.b),              .neg(sb),     .res(b_abs));
   mdu_sign_fix #(.WIDTH(2*WIDTH)) u_fix_p  (.val(acc_q),              .neg(neg_q),  .res(prod_fix));
   mdu_sign_fix #(.WIDTH(WIDTH))   u_fix_q  (.val(acc_q[WIDTH-1:0]),   .neg(neg_q),  .res(quo_fix));
   mdu_sign_fix #(.WIDTH(WIDTH))   u_fix_r  (.val(rem_q),              .neg(rneg_q), .res(rem_fix));

   assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};

   // Restoring step on the WIDTH+1-bit shifted remainder; a set top bit already exceeds any divisor.
   assign shifted = {rem_q, acc_q[WIDTH-1]};
   assign diff    = shifted - {1'b0, opnd_q};
   assign ge      = shifted[WIDTH] | ~diff[WIDTH];

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
`ifdef MDU_DIVZERO_EXC_EN
               state_d = dz_case ? DONE : CALC;
`else
               state_d = CALC;
`endif
            end
         end
         CALC:    if (last_step) state_d = FIX;
         FIX:     state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         cnt_q    <= '0;
         opnd_q   <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
`ifdef MDU_DIVZERO_EXC_EN
         dz_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  is_div_q <= div_op;
                  neg_q    <= sa ^ sb;
                  rneg_q   <= sa;
                  opnd_q   <= div_op ? b_abs : a_abs;
                  acc_q    <= {{WIDTH{1'b0}}, (div_op ? a_abs : b_abs)};
                  rem_q    <= '0;
                  cnt_q    <= '0;
`ifdef MDU_DIVZERO_EXC_EN
                  dz_q     <= dz_case;
`endif
               end else begin
                  if (bus.hi_we) hi_q <= bus.wdata;
                  if (bus.lo_we) lo_q <= bus.wdata;
               end
            end
            CALC: begin
               cnt_q <= cnt_q + CW'(1);
               if (is_div_q) begin
                  rem_q             <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                  acc_q[WIDTH-1:0]  <= {acc_q[WIDTH-2:0], ge};
               end else begin
                  acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
               end
            end
            FIX: begin
               hi_q <= is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
               lo_q <= is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (state_q == CALC) || (state_q == FIX);
   assign bus.done = (state_q == DONE);
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
`ifdef MDU_DIVZERO_EXC_EN
   assign bus.div_zero = (state_q == DONE) && dz_q;
`else
   assign bus.div_zero = 1'b0;
`endif
endmodule
